// File: rtl/sha_pad.sv
// sha_pad: SHA-256 padder feeding sha_core 16 words per block; SHA_PAD_BSWAP_EN selects little-endian msg_dat.
// Latency: one cycle from msg handshake (or pad slot) to core_vld; a single INIT cycle precedes the first word.
// Backpressure: msg_rdy only in data slots (stalls insert bubbles); each block waits for core_done.
module sha_pad #(
    parameter int LEN_W = 16
) (
    input  logic             CLK_I,
    input  logic             RST_I,
    input  logic             start,
    input  logic [LEN_W-1:0] msg_len,
    input  logic [31:0]      msg_dat,
    input  logic             msg_vld,
    output logic             msg_rdy,
    output logic             busy,
    output logic             pad_done,
    output logic             core_init,
    output logic             core_vld,
    output logic [31:0]      core_din,
    input  logic             core_done
);

    // block counter holds up to floor((2^LEN_W+7)/64), one bit wider than LEN_W-5
    localparam int BLK_W = LEN_W - 4;

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        SEND,
        WAIT,
        DONE
    } state_t;

    state_t           state;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-3:0] nw_q;
    logic [1:0]       r_q;
    logic [BLK_W-1:0] nb_m1_q;
    logic [BLK_W-1:0] blk;
    logic [3:0]       wcnt;

    logic [LEN_W:0]   len_p8;
    logic [LEN_W-1:0] g;
    logic [LEN_W-1:0] nw_ext;
    logic [63:0]      bitlen;
    logic [31:0]      src_word;
    logic             last_blk;
    logic             is_tail;
    logic             in_slot;
    logic             emit;
    logic [31:0]      data_word;
    logic [31:0]      pad_word;

    assign len_p8   = {1'b0, msg_len} + (LEN_W+1)'(8);
    assign g        = {blk, wcnt};
    assign nw_ext   = {2'b00, nw_q};
    assign bitlen   = {{(61-LEN_W){1'b0}}, len_q, 3'b000};
    assign last_blk = (blk == nb_m1_q);
    assign is_tail  = (g == nw_ext);

`ifdef SHA_PAD_BSWAP_EN
    assign src_word = {msg_dat[7:0], msg_dat[15:8], msg_dat[23:16], msg_dat[31:24]};
`else
    assign src_word = msg_dat;
`endif

    // decode the current slot: input-sourced (full or tail word) versus generated pad/length word
    always_comb begin
        in_slot   = (g < nw_ext) || (is_tail && (r_q != 2'd0));
        emit      = in_slot ? msg_vld : 1'b1;
        data_word = src_word;
        if (is_tail) begin
            case (r_q)
                2'd1:    data_word = {src_word[31:24], 8'h80, 16'h0000};
                2'd2:    data_word = {src_word[31:16], 8'h80, 8'h00};
                2'd3:    data_word = {src_word[31:8], 8'h80};
                default: data_word = src_word;
            endcase
        end
        pad_word = 32'h0000_0000;
        if (is_tail)
            pad_word = 32'h8000_0000;
        else if (last_blk && (wcnt == 4'd14))
            pad_word = bitlen[63:32];
        else if (last_blk && (wcnt == 4'd15))
            pad_word = bitlen[31:0];
    end

    // the source is only asked for data while a data slot is being filled
    assign msg_rdy = (state == SEND) && in_slot;

    // control FSM with registered core-side outputs
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            state     <= IDLE;
            busy      <= 1'b0;
            pad_done  <= 1'b0;
            core_init <= 1'b0;
            core_vld  <= 1'b0;
            core_din  <= 32'h0;
            len_q     <= '0;
            nw_q      <= '0;
            r_q       <= 2'd0;
            nb_m1_q   <= '0;
            blk       <= '0;
            wcnt      <= 4'd0;
        end else begin
            core_init <= 1'b0;
            core_vld  <= 1'b0;
            pad_done  <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    state <= IDLE;
                    if (start) begin
                        len_q     <= msg_len;
                        nw_q      <= msg_len[LEN_W-1:2];
                        r_q       <= msg_len[1:0];
                        nb_m1_q   <= BLK_W'(len_p8 >> 6);
                        blk       <= '0;
                        wcnt      <= 4'd0;
                        busy      <= 1'b1;
                        core_init <= 1'b1;
                        state     <= INIT;
                    end
                end
                INIT: begin
                    state <= SEND;
                end
                SEND: begin
                    if (emit) begin
                        core_vld <= 1'b1;
                        core_din <= in_slot ? data_word : pad_word;
                        wcnt     <= wcnt + 4'd1;
                        if (wcnt == 4'd15)
                            state <= WAIT;
                    end
                end
                WAIT: begin
                    if (core_done) begin
                        if (last_blk) begin
                            pad_done <= 1'b1;
                            busy     <= 1'b0;
                            state    <= DONE;
                        end else begin
                            blk   <= blk + BLK_W'(1);
                            state <= SEND;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
